// File: rtl/stp_sched_pkg.sv
// Shared definitions for the stream-port channel scheduler.
// Holds the scheduler state encoding, the channel-select width shared with
// the 16-way stream mux, and the default channel count and guard length.
package stp_sched_pkg;

  localparam int CH_W          = 8;
  localparam int DEF_NUM_CH    = 16;
  localparam int DEF_GUARD_CYC = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/stp_rr_pick.sv
// Combinational round-robin first-set-bit finder.
// Ports:
//   elig   - eligible channel vector (req & ch_mask)
//   rr_ptr - index of the last served channel; search starts at rr_ptr+1
//   valid  - at least one channel is eligible
//   index  - winning channel index
module stp_rr_pick #(
  parameter int NUM_CH = 16,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [IW-1:0]     rr_ptr,
  output logic              valid,
  output logic [IW-1:0]     index
);

  int pos;

  // Walk upward from rr_ptr+1, wrapping, and keep the first hit.
  always_comb begin
    valid = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      pos = (int'(rr_ptr) + k) % NUM_CH;
      if (!valid && elig[pos[IW-1:0]]) begin
        valid = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/stp_channel_sched.sv
// Round-robin scheduler owning the channel select of the 16-way stream mux.
// Picks a requesting source, steers the mux, waits a settle guard, grants
// until end of packet, then waits a release guard before re-arbitrating.
// Optional feature macro: STP_SCHED_TIMEOUT_EN (grant timeout counter).
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   ch_mask        - per-channel arbitration enable
//   req            - per-channel level request
//   done           - end-of-packet pulse from the granted channel
//   timeout_lim    - max ACTIVE cycles per grant, 0 = unlimited
//   channel        - registered, zero-extended mux select
//   gnt            - registered one-hot grant, zero outside ACTIVE
//   busy           - high whenever not IDLE
//   timeout_pulse  - one-cycle pulse on a timed-out grant
//   timeout_ch     - index of the last timed-out channel
module stp_channel_sched
  import stp_sched_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    done,
  input  logic [TIMEOUT_W-1:0] timeout_lim,
  output logic [CH_W-1:0]      channel,
  output logic [NUM_CH-1:0]    gnt,
  output logic                 busy,
  output logic                 timeout_pulse,
  output logic [CH_W-1:0]      timeout_ch
);

  localparam int IW = $clog2(NUM_CH);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  sched_state_t  state;
  logic [IW-1:0] cur;
  logic [IW-1:0] rr_ptr;
  logic [GW-1:0] guard;
  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic          tmo_hit;

  stp_rr_pick #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_pick (
    .elig   (req & ch_mask),
    .rr_ptr (rr_ptr),
    .valid  (win_valid),
    .index  (win_idx)
  );

`ifdef STP_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  assign tmo_hit = (timeout_lim != '0) && (tmo_cnt == timeout_lim - TIMEOUT_W'(1));
`else
  logic unused_timeout_lim;
  assign unused_timeout_lim = ^timeout_lim;
  assign tmo_hit            = 1'b0;
  assign timeout_pulse      = 1'b0;
  assign timeout_ch         = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      channel <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      cur     <= '0;
      rr_ptr  <= IW'(NUM_CH - 1);
      guard   <= '0;
`ifdef STP_SCHED_TIMEOUT_EN
      tmo_cnt       <= '0;
      timeout_pulse <= 1'b0;
      timeout_ch    <= '0;
`endif
    end else begin
`ifdef STP_SCHED_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        // channel only moves here, so the mux never glitches while granted.
        IDLE: begin
          if (win_valid) begin
            channel <= CH_W'(win_idx);
            cur     <= win_idx;
            guard   <= GW'(GUARD_CYC - 1);
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (guard == '0) begin
            gnt   <= ONE_HOT0 << cur;
            state <= ACTIVE;
`ifdef STP_SCHED_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else begin
            guard <= guard - GW'(1);
          end
        end
        // Only the granted channel's done/req/mask matter here.
        ACTIVE: begin
`ifdef STP_SCHED_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
`endif
          if (done[cur] || !req[cur] || !ch_mask[cur] || tmo_hit) begin
            gnt   <= '0;
            guard <= GW'(GUARD_CYC - 1);
            state <= RELEASE;
`ifdef STP_SCHED_TIMEOUT_EN
            // A packet finishing on the timeout cycle is a normal completion.
            if (tmo_hit && !done[cur]) begin
              timeout_pulse <= 1'b1;
              timeout_ch    <= CH_W'(cur);
            end
`endif
          end
        end
        RELEASE: begin
          if (guard == '0) begin
            rr_ptr <= cur;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            guard <= guard - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stp_channel_sched.md
# stp_channel_sched

Round-robin scheduler that owns the 8-bit `channel` select of the 16-way stream mux and shares the single downstream stream port among 16 source channels. Sources raise a request when a packet is ready. The scheduler picks one source and steers the mux to it. It waits a guard interval so the muxed source clock can settle, grants the source until end of packet, then waits a second guard interval before it re-arbitrates. The block sits between the per-channel stream sources and the mux, in the system clock domain.

## Interface
- NUM_CH, 16, number of source channels (2..16)
- GUARD_CYC, 4, settle/release guard length in cycles (>=1)
- TIMEOUT_W, 16, width of the grant-timeout counter and limit
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ch_mask  in  NUM_CH  1 = channel eligible for arbitration
- req  in  NUM_CH  level request per channel; held until granted packet ends
- done  in  NUM_CH  single-cycle end-of-packet pulse from the granted channel
- timeout_lim  in  TIMEOUT_W  maximum ACTIVE cycles per grant; 0 = unlimited
- channel  out  8  mux select, registered, zero-extended channel index
- gnt  out  NUM_CH  one-hot grant, registered; all-zero outside ACTIVE
- busy  out  1  high in any state other than IDLE
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout
- timeout_ch  out  8  index of the last timed-out channel; held until the next timeout

## Operation
- FSM states: IDLE, SETTLE, ACTIVE, RELEASE.
- Reset values: state=IDLE, channel=0, gnt=0, busy=0, timeout_pulse=0, timeout_ch=0, rr_ptr=NUM_CH-1. With this pointer value the first search starts at channel 0.
- Eligible vector: `req & ch_mask`. The winner is the first set bit found by searching upward from rr_ptr+1, wrapping modulo NUM_CH.
- IDLE: if any channel is eligible, load channel=winner, cur=winner, guard count=GUARD_CYC-1, then go to SETTLE. If none is eligible, stay in IDLE; channel keeps its last value and never toggles spuriously.
- SETTLE: gnt=0. Decrement the guard count. At 0, go to ACTIVE and set gnt[cur]=1.
- ACTIVE: gnt[cur]=1 and channel is held stable. Exit to RELEASE on any of the following:
  - done[cur] is high;
  - req[cur] is low (abort);
  - ch_mask[cur] is low;
  - the timeout fires (see Configuration).
- ACTIVE: done, req and mask changes on other channels are ignored.
- RELEASE: gnt=0, channel held, guard count=GUARD_CYC-1 on entry. Decrement the guard count. At 0, set rr_ptr=cur and go to IDLE.
- Simultaneous events in ACTIVE: done[cur] together with timeout counts as normal completion, with no timeout_pulse.
- Requests arriving during SETTLE, ACTIVE or RELEASE wait for the next IDLE evaluation.
- Reset mid-operation: all outputs return to their reset values immediately and asynchronously; any in-flight grant is dropped.

## Timing
- req is sampled in IDLE at edge n. channel updates at edge n+1, and gnt rises at edge n+1+GUARD_CYC.
- done[cur] sampled at edge m: gnt falls at m+1, and the next channel change occurs no earlier than m+GUARD_CYC+2.
- busy is registered and tracks the state: low only in IDLE.
- Back-to-back grants to the same channel are allowed. If that channel is the only one eligible, it wins again after RELEASE.
- channel never changes while gnt is non-zero, nor during RELEASE.

## Configuration
- Macro: STP_SCHED_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When the counter equals timeout_lim-1, timeout_lim!=0, and done[cur] is low, the block asserts timeout_pulse for one cycle, loads timeout_ch=cur, and moves to RELEASE.
- Not defined:
  - No counter is built and timeout_lim is ignored.
  - timeout_pulse and timeout_ch are tied to 0.
  - ACTIVE exits only on done, req drop or mask drop.

## Structure
- Package stp_sched_pkg holds:
  - the state enum (IDLE, SETTLE, ACTIVE, RELEASE);
  - CH_W=8, the channel-select width shared with the mux;
  - the default NUM_CH and GUARD_CYC constants.
- Sub-module stp_rr_pick holds the combinational round-robin first-set-bit finder. Inputs: eligible vector and rr_ptr. Outputs: valid and index. The FSM, counters and output registers remain in stp_channel_sched.

## Test plan
- Reset, then req=0x0001 with mask=0xFFFF: channel=0 one cycle after sampling, gnt=0x0001 after a further 4 cycles. Pulse done[0]: gnt=0 on the next cycle and busy low 4 cycles later.
- req=0xFFFF held, done pulsed 2 cycles after each grant: grant order 0,1,2,…,15,0, with one channel change per grant.
- req=0x0011, mask=0x0010: channel 0 is never selected and channel 4 is granted repeatedly.
- timeout_lim=10 with the macro defined and no done: gnt drops after exactly 10 ACTIVE cycles, timeout_pulse=1 for one cycle, timeout_ch equals the granted index. Repeat without the macro: the grant holds indefinitely.
- done pulse on a non-granted channel during ACTIVE is ignored. req[cur] dropped mid-grant leads to RELEASE. rst_n asserted during SETTLE forces channel=0, gnt=0 and busy=0 immediately.
